// File: rtl/fetch_queue.sv
// Dual-issue instruction buffer between fetch and the dual decoder.
// Circular {pc, instr} store with show-ahead lanes A/B; flush drops everything.
module fetch_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid_a,
   input  logic [31:0]      in_pc_a,
   input  logic [31:0]      in_instr_a,
   input  logic             in_valid_b,
   input  logic [31:0]      in_pc_b,
   input  logic [31:0]      in_instr_b,
   output logic             in_ready,
   output logic             out_valid_a,
   output logic [31:0]      out_pc_a,
   output logic [31:0]      out_instr_a,
   output logic             out_valid_b,
   output logic [31:0]      out_pc_b,
   output logic [31:0]      out_instr_b,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
);

   logic [31:0]      pc_mem    [DEPTH];
   logic [31:0]      instr_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr_inc;
   logic [PTR_W-1:0] rd_ptr_inc;
   logic             do_push;
   logic             wr_first;
   logic             wr_second;
   logic [31:0]      first_pc;
   logic [31:0]      first_instr;
   logic [1:0]       push_cnt;
   logic [1:0]       pop_cnt;
   logic [CNT_W:0]   count_sum;

   assign wr_ptr_inc = wr_ptr + PTR_W'(1);
   assign rd_ptr_inc = rd_ptr + PTR_W'(1);

   // in_ready looks only at registered occupancy, so out_ready never reaches it
   assign in_ready = (count <= CNT_W'(DEPTH - 2));

   assign out_valid_a = (count != '0);
   assign out_valid_b = (count >= CNT_W'(2));
   assign out_pc_a    = out_valid_a ? pc_mem[rd_ptr]        : '0;
   assign out_instr_a = out_valid_a ? instr_mem[rd_ptr]     : '0;
   assign out_pc_b    = out_valid_b ? pc_mem[rd_ptr_inc]    : '0;
   assign out_instr_b = out_valid_b ? instr_mem[rd_ptr_inc] : '0;

   // A lone B entry is compacted into the first free slot
   always_comb begin
      do_push     = in_ready && !flush && !reset;
      wr_first    = do_push && (in_valid_a || in_valid_b);
      wr_second   = do_push && in_valid_a && in_valid_b;
      first_pc    = in_valid_a ? in_pc_a    : in_pc_b;
      first_instr = in_valid_a ? in_instr_a : in_instr_b;
      push_cnt    = '0;
      if (do_push) begin
         push_cnt = {1'b0, in_valid_a} + {1'b0, in_valid_b};
      end
      pop_cnt = '0;
      if (out_ready && !flush) begin
         pop_cnt = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];
      end
      count_sum = {1'b0, count} + (CNT_W + 1)'(push_cnt) - (CNT_W + 1)'(pop_cnt);
   end

   always_ff @(posedge clk) begin
      if (wr_first) begin
         pc_mem[wr_ptr]    <= first_pc;
         instr_mem[wr_ptr] <= first_instr;
      end
      if (wr_second) begin
         pc_mem[wr_ptr_inc]    <= in_pc_b;
         instr_mem[wr_ptr_inc] <= in_instr_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         assert (count_sum <= (CNT_W + 1)'(DEPTH));
         wr_ptr <= wr_ptr + PTR_W'(push_cnt);
         rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
         count  <= count_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_fetch_queue;

   localparam int DEPTH = 8;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid_a;
   logic [31:0] in_pc_a;
   logic [31:0] in_instr_a;
   logic        in_valid_b;
   logic [31:0] in_pc_b;
   logic [31:0] in_instr_b;
   logic        in_ready;
   logic        out_valid_a;
   logic [31:0] out_pc_a;
   logic [31:0] out_instr_a;
   logic        out_valid_b;
   logic [31:0] out_pc_b;
   logic [31:0] out_instr_b;
   logic        out_ready;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;

   // Reference model: plain FIFO of {pc, instr}, front = oldest
   logic [63:0] mq[$];

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid_a(in_valid_a), .in_pc_a(in_pc_a), .in_instr_a(in_instr_a),
      .in_valid_b(in_valid_b), .in_pc_b(in_pc_b), .in_instr_b(in_instr_b),
      .in_ready(in_ready),
      .out_valid_a(out_valid_a), .out_pc_a(out_pc_a), .out_instr_a(out_instr_a),
      .out_valid_b(out_valid_b), .out_pc_b(out_pc_b), .out_instr_b(out_instr_b),
      .out_ready(out_ready), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic va, input logic [31:0] pa, input logic [31:0] ia,
                        input logic vb, input logic [31:0] pb, input logic [31:0] ib,
                        input logic ordy, input logic fl);
      in_valid_a = va; in_pc_a = pa; in_instr_a = ia;
      in_valid_b = vb; in_pc_b = pb; in_instr_b = ib;
      out_ready  = ordy; flush = fl;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   // Advance the model with the currently driven inputs, then clock the DUT
   task automatic cycle();
      int  pops;
      bit  rdy;
      rdy = (DEPTH - mq.size()) >= 2;
      if (reset || flush) begin
         mq.delete();
      end else begin
         if (out_ready) begin
            pops = (mq.size() >= 2) ? 2 : mq.size();
            repeat (pops) void'(mq.pop_front());
         end
         if (rdy) begin
            if (in_valid_a) mq.push_back({in_pc_a, in_instr_a});
            if (in_valid_b) mq.push_back({in_pc_b, in_instr_b});
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model_lane(input int lane);
      return (mq.size() > lane) ? mq[lane] : 64'h0;
   endfunction

   task automatic test_reset();
      idle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      checks++;
      if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
      checks++;
      if ({out_valid_a, out_valid_b} !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_valid got %b want 00", {out_valid_a, out_valid_b});
      end
      checks++;
      if ({out_pc_a, out_pc_b, out_instr_a, out_instr_b} !== 128'h0) begin
         errors++; $display("[TB] FAIL reset_lanes got %h %h %h %h want zeros", out_pc_a, out_pc_b, out_instr_a, out_instr_b);
      end
   endtask

   task automatic test_single_pair();
      drive(1'b1, 32'h0, 32'h00500093, 1'b1, 32'h4, 32'h00A00113, 1'b0, 1'b0);
      cycle();
      idle();
      checks++;
      if (count !== 4'd2) begin errors++; $display("[TB] FAIL pair_count got %0d want 2", count); end
      checks++;
      if ({out_valid_a, out_pc_a, out_instr_a} !== {1'b1, 32'h0, 32'h00500093}) begin
         errors++; $display("[TB] FAIL pair_lane_a got %b %h %h want 1 0 00500093", out_valid_a, out_pc_a, out_instr_a);
      end
      checks++;
      if ({out_valid_b, out_pc_b, out_instr_b} !== {1'b1, 32'h4, 32'h00A00113}) begin
         errors++; $display("[TB] FAIL pair_lane_b got %b %h %h want 1 4 00a00113", out_valid_b, out_pc_b, out_instr_b);
      end
      out_ready = 1'b1;
      cycle();
      idle();
      checks++;
      if (count !== 4'd0) begin errors++; $display("[TB] FAIL pair_drain got %0d want 0", count); end
   endtask

   task automatic test_b_only();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h8, 32'h12345678, 1'b0, 1'b0);
      cycle();
      idle();
      checks++;
      if ({count, out_valid_a, out_pc_a, out_instr_a, out_valid_b} !== {4'd1, 1'b1, 32'h8, 32'h12345678, 1'b0}) begin
         errors++;
         $display("[TB] FAIL b_only got cnt=%0d va=%b pc=%h ins=%h vb=%b want cnt=1 va=1 pc=8 ins=12345678 vb=0",
                  count, out_valid_a, out_pc_a, out_instr_a, out_valid_b);
      end
      out_ready = 1'b1;
      cycle();
      idle();
   endtask

   task automatic test_fill();
      for (int p = 0; p < 4; p++) begin
         drive(1'b1, 32'(p * 8), 32'(p + 100), 1'b1, 32'(p * 8 + 4), 32'(p + 200), 1'b0, 1'b0);
         cycle();
         checks++;
         if (in_ready !== (p < 3)) begin
            errors++; $display("[TB] FAIL fill_in_ready pair %0d got %b want %b", p, in_ready, (p < 3));
         end
      end
      checks++;
      if (count !== 4'd8) begin errors++; $display("[TB] FAIL fill_count got %0d want 8", count); end
      drive(1'b1, 32'h20, 32'hDEAD, 1'b1, 32'h24, 32'hBEEF, 1'b0, 1'b0);
      cycle();
      idle();
      checks++;
      if (count !== 4'd8) begin errors++; $display("[TB] FAIL fill_drop got %0d want 8", count); end
      for (int p = 0; p < 4; p++) begin
         out_ready = 1'b1;
         checks++;
         if ({out_pc_a, out_pc_b} !== {32'(p * 8), 32'(p * 8 + 4)}) begin
            errors++; $display("[TB] FAIL fill_order step %0d got %h/%h want %h/%h", p, out_pc_a, out_pc_b, p * 8, p * 8 + 4);
         end
         cycle();
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready_back step %0d got %b want 1", p, in_ready); end
      end
      idle();
      checks++;
      if (count !== 4'd0) begin errors++; $display("[TB] FAIL fill_empty got %0d want 0", count); end
   endtask

   task automatic test_wrap();
      logic [31:0] base;
      logic [31:0] next_pc;
      base = 32'h100;
      next_pc = base;
      for (int k = 0; k <= 20; k++) begin
         if (k < 20) drive(1'b1, base + 32'(k * 8), 32'(k), 1'b1, base + 32'(k * 8 + 4), 32'(k + 50), 1'b1, 1'b0);
         else        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         if (out_valid_a) begin
            checks++;
            if (out_pc_a !== next_pc) begin errors++; $display("[TB] FAIL wrap_order_a got %h want %h", out_pc_a, next_pc); end
            next_pc += 4;
         end
         if (out_valid_b) begin
            checks++;
            if (out_pc_b !== next_pc) begin errors++; $display("[TB] FAIL wrap_order_b got %h want %h", out_pc_b, next_pc); end
            next_pc += 4;
         end
         cycle();
         checks++;
         if (count !== ((k < 20) ? 4'd2 : 4'd0)) begin
            errors++; $display("[TB] FAIL wrap_count cycle %0d got %0d want %0d", k, count, (k < 20) ? 2 : 0);
         end
      end
      idle();
      checks++;
      if (next_pc !== base + 32'd160) begin errors++; $display("[TB] FAIL wrap_total got %h want %h", next_pc, base + 32'd160); end
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h200, 32'h1, 1'b1, 32'h204, 32'h2, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h208, 32'h3, 1'b1, 32'h20C, 32'h4, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h210, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
      checks++;
      if (count !== 4'd5) begin errors++; $display("[TB] FAIL flush_setup got %0d want 5", count); end
      drive(1'b1, 32'h300, 32'h6, 1'b1, 32'h304, 32'h7, 1'b1, 1'b1);
      checks++;
      if ({out_valid_a, out_pc_a} !== {1'b1, 32'h200}) begin
         errors++; $display("[TB] FAIL flush_preview got %b %h want 1 200", out_valid_a, out_pc_a);
      end
      cycle();
      idle();
      checks++;
      if ({count, out_valid_a} !== {4'd0, 1'b0}) begin
         errors++; $display("[TB] FAIL flush_clear got cnt=%0d va=%b want 0 0", count, out_valid_a);
      end
      cycle();
      checks++;
      if ({count, out_valid_a, out_pc_a} !== {4'd0, 1'b0, 32'h0}) begin
         errors++; $display("[TB] FAIL flush_no_ghost got cnt=%0d va=%b pc=%h want 0 0 0", count, out_valid_a, out_pc_a);
      end
      drive(1'b1, 32'h400, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
      idle();
      out_ready = 1'b1;
      checks++;
      if ({count, out_valid_b} !== {4'd1, 1'b0}) begin
         errors++; $display("[TB] FAIL odd_setup got cnt=%0d vb=%b want 1 0", count, out_valid_b);
      end
      cycle();
      idle();
      checks++;
      if ({count, out_valid_a, out_valid_b} !== {4'd0, 1'b0, 1'b0}) begin
         errors++; $display("[TB] FAIL odd_pop got cnt=%0d va=%b vb=%b want 0 0 0", count, out_valid_a, out_valid_b);
      end
   endtask

   task automatic test_random();
      logic [134:0] got;
      logic [134:0] want;
      logic [63:0]  la;
      logic [63:0]  lb;
      idle();
      reset = 1'b1; cycle(); reset = 1'b0;
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, $urandom, $urandom,
               $urandom_range(0, 2) != 0, $urandom, $urandom,
               $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
         reset = ($urandom_range(0, 99) == 0);
         la = model_lane(0);
         lb = model_lane(1);
         want = {4'(mq.size()), 1'((DEPTH - mq.size()) >= 2), 1'(mq.size() >= 1), 1'(mq.size() >= 2),
                 la[63:32], la[31:0], lb[63:32], lb[31:0]};
         got  = {count, in_ready, out_valid_a, out_valid_b, out_pc_a, out_instr_a, out_pc_b, out_instr_b};
         checks++;
         if (got !== want) begin
            errors++; $display("[TB] FAIL random cycle %0d got %h want %h", n, got, want);
         end
         cycle();
      end
      reset = 1'b0;
      idle();
   endtask

   initial begin
      reset = 1'b0;
      idle();
      test_reset();
      test_single_pair();
      test_b_only();
      test_fill();
      test_wrap();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-issue instruction buffer between the fetch stage and the dual decoder.
- Accepts 0–2 fetched {pc, instr} pairs per cycle and presents 0–2 in-order pairs per cycle to decode as lanes A and B.
- Absorbs decode stalls without back-pressuring fetch mid-pair.
- Drops all contents on a pipeline flush (branch redirect).

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH), read/write pointer width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all entries; synchronous
- in_valid_a  input  1  fetch lane A holds an instruction
- in_pc_a  input  32  lane A PC
- in_instr_a  input  32  lane A instruction word
- in_valid_b  input  1  fetch lane B holds an instruction (program order: after A)
- in_pc_b  input  32  lane B PC
- in_instr_b  input  32  lane B instruction word
- in_ready  output  1  at least 2 free entries; push is allowed this cycle
- out_valid_a  output  1  head entry present
- out_pc_a  output  32  head entry PC
- out_instr_a  output  32  head entry instruction
- out_valid_b  output  1  second entry present
- out_pc_b  output  32  second entry PC
- out_instr_b  output  32  second entry instruction
- out_ready  input  1  decode consumes every valid output lane this cycle
- count  output  CNT_W  current occupancy, for debug and hazard logic

Behaviour:
- Reset (synchronous, active-high): wr_ptr=0, rd_ptr=0, count=0.
  - All out_valid_* = 0, in_ready = 1, out_pc_* = 0, out_instr_* = 0.
  - Storage contents are don't-care.
- Storage is a circular array of {pc, instr}; pointers wrap modulo DEPTH.
- Outputs are show-ahead and combinational from registered state only:
  - Lane A = entry[rd_ptr]. Lane B = entry[rd_ptr+1 mod DEPTH].
  - out_valid_a = (count≥1); out_valid_b = (count≥2).
  - Invalid lanes drive pc and instr = 0.
- in_ready = (DEPTH − count ≥ 2).
  - Depends only on registered count, not on a same-cycle pop. No combinational path from out_ready to in_ready.
- Push (when in_ready=1 and flush=0):
  - valid A and B: write A at wr_ptr, B at wr_ptr+1; push count = 2.
  - A only: write A at wr_ptr; push count = 1.
  - B only: compact, writing B at wr_ptr; push count = 1.
  - Neither: no write.
- Push with in_ready=0: inputs ignored, no write. Fetch is responsible for holding its pair.
- Pop (when out_ready=1 and flush=0): pop count = min(count, 2). rd_ptr advances by the pop count.
- Simultaneous push and pop in one cycle:
  - count_next = count + pushes − pops.
  - A pop of an entry and a write to a freed slot in the same cycle never collide, because in_ready guarantees 2 slots free before the pop.
- Empty plus push: new entries appear on the outputs in the next cycle. There is no same-cycle bypass; latency is 1 cycle.
- Full (count = DEPTH or DEPTH−1): in_ready=0, and pops still proceed.
- Flush (flush=1):
  - Next cycle: wr_ptr=rd_ptr=count=0.
  - Same-cycle push and pop are ignored; flush has priority over both.
  - Same-cycle outputs still show the pre-flush state. Decode must qualify them with flush.
- Priority of concurrent controls: reset > flush > push/pop.
- Pointer arithmetic is PTR_W bits with natural wrap. Count never exceeds DEPTH; an assertion in simulation flags any overflow or underflow.

Test Plan:
- Reset then idle: after reset=1 for 1 cycle → count=0, in_ready=1, out_valid_a=out_valid_b=0, all out_pc_*=0.
- Single pair: push A{pc=0x0,instr=0x00500093}, B{pc=0x4,instr=0x00A00113} with out_ready=0 → next cycle count=2, lane A pc=0x0, lane B pc=0x4. Then out_ready=1 for 1 cycle → count=0.
- B-only compaction: push only B{pc=0x8} into an empty queue → next cycle out_valid_a=1, out_pc_a=0x8, out_valid_b=0, count=1.
- Fill and back-pressure with DEPTH=8:
  - Push 4 pairs (pc 0x0..0x1C) with out_ready=0 → count=8, in_ready=0.
  - A 5th pair presented is dropped.
  - Then out_ready=1 for 4 cycles → lanes read 0x0/0x4, 0x8/0xC, 0x10/0x14, 0x18/0x1C in order, and in_ready returns to 1 once count≤6.
- Wrap-around with concurrent push and pop: stream 20 consecutive pairs with out_ready=1 every cycle → count holds at 2 steady-state, PCs exit in strict ascending order across pointer wrap, no loss or duplication.
- Flush priority: count=5, and in one cycle flush=1, a pair is pushed, and out_ready=1 → next cycle count=0, out_valid_a=0. The pushed pair never appears. An odd single-entry pop (count=1, out_ready=1) → count=0, out_valid_b stayed 0.
